// File: rtl/input_conditioner.sv
// input_conditioner: two-flop synchronizer plus a 4-state debounce FSM for lab FSM input A
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high
//   btn_raw  in   raw asynchronous switch/button
//   a_level  out  debounced level (toggle register when CONDITIONER_TOGGLE_EN is defined)
//   a_rise   out  one-cycle strobe on accepted 0->1
//   a_fall   out  one-cycle strobe on accepted 1->0
//   busy     out  high while a candidate change is being qualified
// Macro CONDITIONER_TOGGLE_EN: a_level flips on each accepted rise instead of following the button.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic a_level,
    output logic a_rise,
    output logic a_fall,
    output logic busy
);
    typedef enum logic [1:0] {
        IDLE_LOW   = 2'd0,
        CHECK_HIGH = 2'd1,
        IDLE_HIGH  = 2'd2,
        CHECK_LOW  = 2'd3
    } state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic sync1_q, sync1_d, sync2_q, sync2_d;
    logic level_q, level_d, rise_q, rise_d, fall_q, fall_d;
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        state_d = IDLE_LOW;
        cnt_d   = '0;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            IDLE_LOW: begin
                state_d = sync2_q ? CHECK_HIGH : IDLE_LOW;
                cnt_d   = sync2_q ? CNT_W'(1) : '0;
            end
            CHECK_HIGH: begin
                if (!sync2_q) state_d = IDLE_LOW;
                else if (cnt_q == LAST) begin
                    state_d = IDLE_HIGH;
                    rise_d  = 1'b1;
                end else begin
                    state_d = CHECK_HIGH;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            IDLE_HIGH: begin
                state_d = sync2_q ? IDLE_HIGH : CHECK_LOW;
                cnt_d   = sync2_q ? '0 : CNT_W'(1);
            end
            CHECK_LOW: begin
                if (sync2_q) state_d = IDLE_HIGH;
                else if (cnt_q == LAST) begin
                    state_d = IDLE_LOW;
                    fall_d  = 1'b1;
                end else begin
                    state_d = CHECK_LOW;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE_LOW;
        endcase
`ifdef CONDITIONER_TOGGLE_EN
        level_d = rise_d ? ~level_q : level_q;
`else
        // high states are the ones with bit 1 set; using the next state aligns a_level with a_rise/a_fall
        level_d = state_d[1];
`endif
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end
    assign a_level = level_q;
    assign a_rise  = rise_q;
    assign a_fall  = fall_q;
    // CHECK_HIGH and CHECK_LOW are the odd encodings
    assign busy    = state_q[0];
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: randomized and directed checks of input_conditioner against a queue-based model
module tb_input_conditioner;
    localparam int DEB = 4;
    logic clk = 1'b0, reset = 1'b1, btn_raw = 1'b0;
    logic a_level, a_rise, a_fall, busy;
    int n_cmp = 0, n_bad = 0;
    // model: raw samples waiting to emerge from the synchronizer, and the run of
    // synchronized samples that disagree with the current debounced level
    bit rq[$];
    bit run[$];
    bit m_deb, m_level, m_rise, m_fall, m_busy;
    input_conditioner #(.DEBOUNCE_CYCLES(DEB), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .btn_raw(btn_raw),
        .a_level(a_level), .a_rise(a_rise), .a_fall(a_fall), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask
    task automatic model_edge(input bit r, input bit b);
        bit s;
        m_rise = 0;
        m_fall = 0;
        if (r) begin
            rq = '{0, 0};
            run.delete();
            m_deb = 0;
            m_level = 0;
            m_busy = 0;
            return;
        end
        s = rq.pop_front();
        rq.push_back(b);
        if (s == m_deb) run.delete();
        else run.push_back(s);
        if (run.size() == DEB) begin
            m_deb = ~m_deb;
            m_rise = m_deb;
            m_fall = ~m_deb;
            run.delete();
`ifdef CONDITIONER_TOGGLE_EN
            if (m_rise) m_level = ~m_level;
`endif
        end
`ifndef CONDITIONER_TOGGLE_EN
        m_level = m_deb;
`endif
        m_busy = (s != m_deb);
    endtask
    // drive one cycle: apply inputs, clock, then compare on the falling edge
    task automatic step(input bit r, input bit b);
        reset = r;
        btn_raw = b;
        @(posedge clk);
        model_edge(r, b);
        @(negedge clk);
        chk("a_level", a_level, m_level);
        chk("a_rise", a_rise, m_rise);
        chk("a_fall", a_fall, m_fall);
        chk("busy", busy, m_busy);
        chk("exclusive", a_rise & a_fall, 1'b0);
    endtask
    initial begin
        bit seen_busy, seen_rise;
        bit lvl0;
        @(negedge clk);
        // reset state
        step(1, 0);
        chk("rst_level", a_level, 0);
        chk("rst_rise", a_rise, 0);
        chk("rst_fall", a_fall, 0);
        chk("rst_busy", busy, 0);
        // rising press: busy from edge 3, accepted at edge 6
        step(0, 1);
        step(0, 1);
        chk("rise_busy_e2", busy, 0);
        step(0, 1);
        chk("rise_busy_e3", busy, 1);
        step(0, 1);
        step(0, 1);
        chk("rise_level_e5", a_level, 0);
        chk("rise_strobe_e5", a_rise, 0);
        step(0, 1);
        chk("rise_level_e6", a_level, 1);
        chk("rise_strobe_e6", a_rise, 1);
        chk("rise_busy_e6", busy, 0);
        step(0, 1);
        chk("rise_strobe_e7", a_rise, 0);
        chk("rise_level_e7", a_level, 1);
        // release: a_fall at edge 6, no a_rise
        seen_rise = 0;
        for (int i = 1; i <= 6; i++) begin
            step(0, 0);
            seen_rise |= a_rise;
            if (i == 5) chk("fall_strobe_e5", a_fall, 0);
        end
        chk("fall_strobe_e6", a_fall, 1);
`ifdef CONDITIONER_TOGGLE_EN
        chk("fall_level_e6", a_level, 1);
`else
        chk("fall_level_e6", a_level, 0);
`endif
        chk("fall_no_rise", seen_rise, 0);
        step(0, 0);
        chk("fall_strobe_e7", a_fall, 0);
        // short glitch: 2 high cycles never qualify
        lvl0 = a_level;
        seen_busy = 0;
        seen_rise = 0;
        for (int i = 1; i <= 10; i++) begin
            step(0, i <= 2);
            seen_busy |= busy;
            seen_rise |= a_rise;
        end
        chk("glitch_busy", seen_busy, 1);
        chk("glitch_no_rise", seen_rise, 0);
        chk("glitch_level", a_level, lvl0);
        // reset mid-qualification with the button still held
        for (int i = 1; i <= 4; i++) step(0, 1);
        chk("midq_busy", busy, 1);
        step(1, 1);
        chk("midq_rst_level", a_level, 0);
        chk("midq_rst_busy", busy, 0);
        chk("midq_rst_rise", a_rise, 0);
        for (int i = 1; i <= 5; i++) step(0, 1);
        chk("midq_rise_e5", a_rise, 0);
        step(0, 1);
        chk("midq_rise_e6", a_rise, 1);
        chk("midq_level_e6", a_level, 1);
        // randomized holds, with occasional reset
        for (int k = 0; k < 600; k++) begin
            bit b = 1'($urandom_range(0, 1));
            int hold = $urandom_range(1, 8);
            for (int i = 0; i < hold; i++) step($urandom_range(0, 59) == 0, b);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
